// File: rtl/pipe_pkg.sv
// pipe_pkg: shared mode enum and sizing helpers for the pipeline valid chain
package pipe_pkg;
  typedef enum logic {PIPE_LOCKSTEP, PIPE_COLLAPSE} pipe_mode_t;
  function automatic int occ_w(input int stages);
    return $clog2(stages + 1);
  endfunction
  function automatic int popcount(input logic [63:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(x[i]);
    return n;
  endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage holding a valid bit and payload, flush beats load and hold
module pipe_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             acc,
  input  logic             up_v,
  input  logic [WIDTH-1:0] up_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      v <= flush ? 1'b0 : acc ? up_v : v;
      d <= acc ? up_d : d;
    end
endmodule

// File: rtl/pipe_valid_chain.sv
// pipe_valid_chain: parametrised valid/data register chain with stall, flush and ready/valid ends
module pipe_valid_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 5,
  parameter int COLLAPSE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  input  logic [STAGES-1:0]           stall,
  input  logic [STAGES-1:0]           flush,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic [STAGES-1:0]           stage_valid,
  output logic [STAGES*WIDTH-1:0]     stage_data,
  output logic [occ_w(STAGES)-1:0]    occupancy
);
  localparam pipe_mode_t MODE = COLLAPSE != 0 ? PIPE_COLLAPSE : PIPE_LOCKSTEP;
  localparam int OCC_W = occ_w(STAGES);
  logic [STAGES:0]         acc;
  logic [STAGES-1:0]       up_v;
  logic [STAGES*WIDTH-1:0] up_d;
  logic                    adv;
  assign adv = !(|stall) && (!stage_valid[STAGES-1] || out_ready);
  // accept ripples from the tail so a stage frees up when its successor moves this cycle
  always_comb begin
    acc[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--)
      acc[i] = MODE == PIPE_COLLAPSE ? (!stall[i] && (!stage_valid[i] || acc[i+1])) : adv;
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_v[i]              = in_valid;
      assign up_d[i*WIDTH+:WIDTH] = in_data;
    end else begin : g_body
      assign up_v[i]              = stage_valid[i-1] && !flush[i-1] && !stall[i-1];
      assign up_d[i*WIDTH+:WIDTH] = stage_data[(i-1)*WIDTH+:WIDTH];
    end
    pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush[i]),
      .acc   (acc[i]),
      .up_v  (up_v[i]),
      .up_d  (up_d[i*WIDTH+:WIDTH]),
      .v     (stage_valid[i]),
      .d     (stage_data[i*WIDTH+:WIDTH])
    );
  end
  assign in_ready  = acc[0];
  assign out_valid = stage_valid[STAGES-1] && !stall[STAGES-1] && !flush[STAGES-1];
  assign out_data  = stage_data[(STAGES-1)*WIDTH+:WIDTH];
  assign occupancy = OCC_W'(popcount(64'(stage_valid)));
endmodule

// File: tb/tb_pipe_valid_chain.sv
// tb_pipe_valid_chain: lockstep and collapsing chains checked against a slot-level reference model
module tb_pipe_valid_chain;
  localparam int W  = 32;
  localparam int S  = 5;
  localparam int OW = $clog2(S + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid, out_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] stall, flush;
  logic ir[2], ov[2];
  logic [W-1:0] od[2];
  logic [S-1:0] sv[2];
  logic [S*W-1:0] sd[2];
  logic [OW-1:0] occ[2];
  pipe_valid_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(0)) u_lock (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .stall(stall), .flush(flush), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .stage_valid(sv[0]), .stage_data(sd[0]), .occupancy(occ[0]));
  pipe_valid_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(1)) u_coll (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .stall(stall), .flush(flush), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .stage_valid(sv[1]), .stage_data(sd[1]), .occupancy(occ[1]));
  bit mv[2][S];
  logic [W-1:0] md[2][S];
  bit macc[2][S+1];
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < S; i++) begin
        mv[m][i] = 1'b0;
        md[m][i] = '0;
      end
  endtask
  // m=0 moves the whole chain or nothing; m=1 lets each slot move when it has somewhere to go
  task automatic model_acc(input int m, input bit ordy, input logic [S-1:0] st);
    bit adv;
    adv = !(|st) && (!mv[m][S-1] || ordy);
    macc[m][S] = ordy;
    for (int i = S - 1; i >= 0; i--)
      macc[m][i] = (m == 1) ? (!st[i] && (!mv[m][i] || macc[m][i+1])) : adv;
  endtask
  task automatic cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                       input logic [S-1:0] st, input logic [S-1:0] fl);
    bit nv[S];
    logic [W-1:0] nd[S];
    logic [S-1:0] ev;
    int cnt;
    in_valid = iv; in_data = id; out_ready = ordy; stall = st; flush = fl;
    #1;
    for (int m = 0; m < 2; m++) begin
      model_acc(m, ordy, st);
      cnt = 0;
      for (int i = 0; i < S; i++) begin
        ev[i] = mv[m][i];
        cnt += int'(mv[m][i]);
      end
      chk($sformatf("m%0d_in_ready", m), W'(ir[m]), W'(macc[m][0]));
      chk($sformatf("m%0d_out_valid", m), W'(ov[m]), W'(mv[m][S-1] && !st[S-1] && !fl[S-1]));
      chk($sformatf("m%0d_out_data", m), od[m], md[m][S-1]);
      chk($sformatf("m%0d_stage_valid", m), W'(sv[m]), W'(ev));
      chk($sformatf("m%0d_occupancy", m), W'(occ[m]), W'(cnt));
      for (int i = 0; i < S; i++)
        if (mv[m][i]) chk($sformatf("m%0d_stage%0d_data", m, i), sd[m][i*W+:W], md[m][i]);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < S; i++) begin
        bit uv;
        logic [W-1:0] ud;
        uv = (i == 0) ? iv : (mv[m][i-1] && !fl[i-1] && !st[i-1]);
        ud = (i == 0) ? id : md[m][i-1];
        nv[i] = fl[i] ? 1'b0 : macc[m][i] ? uv : mv[m][i];
        nd[i] = macc[m][i] ? ud : md[m][i];
      end
      for (int i = 0; i < S; i++) begin
        mv[m][i] = nv[i];
        md[m][i] = nd[i];
      end
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n, input bit ordy);
    repeat (n) cycle(1'b0, '0, ordy, '0, '0);
  endtask
  initial begin
    logic [S-1:0] st, fl;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; stall = '0; flush = '0;
    model_reset();
    #2;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_m%0d_out_valid", m), W'(ov[m]), '0);
      chk($sformatf("rst_m%0d_out_data", m), od[m], '0);
      chk($sformatf("rst_m%0d_occupancy", m), W'(occ[m]), '0);
      chk($sformatf("rst_m%0d_in_ready", m), W'(ir[m]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cycle(1'b1, W'(32'h10 + k), 1'b1, '0, '0);
    chk("t1_occ_peak", W'(occ[1]), 32'd5);
    chk("t1_first_out", od[1], 32'h10);
    idle(6, 1'b1);
    for (int k = 0; k < 7; k++) cycle(1'b1, W'(32'h20 + k), 1'b0, '0, '0);
    chk("t2_full_in_ready", W'(ir[1]), '0);
    chk("t2_full_occ", W'(occ[1]), 32'd5);
    chk("t2_full_head", od[1], 32'h20);
    idle(7, 1'b1);
    cycle(1'b1, 32'hA, 1'b0, '0, '0);
    cycle(1'b0, '0, 1'b0, '0, '0);
    cycle(1'b1, 32'hB, 1'b0, '0, '0);
    idle(5, 1'b0);
    chk("t3_coll_valid", W'(sv[1]), 32'b11000);
    chk("t3_coll_s4", sd[1][4*W+:W], 32'hA);
    chk("t3_coll_s3", sd[1][3*W+:W], 32'hB);
    chk("t3_lock_valid", W'(sv[0]), 32'b10100);
    chk("t3_lock_s2", sd[0][2*W+:W], 32'hB);
    idle(7, 1'b1);
    for (int k = 0; k < 12; k++)
      cycle(1'b1, W'(32'h40 + k), 1'b1, (k >= 3 && k < 6) ? S'(5'b00100) : '0, '0);
    idle(8, 1'b1);
    for (int k = 1; k <= 5; k++) cycle(1'b1, W'(k), 1'b0, '0, '0);
    cycle(1'b1, 32'h6, 1'b0, '0, 5'b01010);
    chk("t5_occ", W'(occ[1]), 32'd3);
    chk("t5_valid", W'(sv[1]), 32'b10101);
    idle(7, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b1, W'(32'h60 + k), 1'b1, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("t6_m%0d_valid", m), W'(sv[m]), '0);
      chk($sformatf("t6_m%0d_occ", m), W'(occ[m]), '0);
      chk($sformatf("t6_m%0d_out_valid", m), W'(ov[m]), '0);
    end
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    cycle(1'b1, 32'h70, 1'b1, '0, '0);
    idle(3, 1'b1);
    chk("t6_latency_early", W'(ov[1]), '0);
    idle(1, 1'b1);
    chk("t6_latency_valid", W'(ov[1]), 32'd1);
    chk("t6_latency_data", od[1], 32'h70);
    idle(6, 1'b1);
    repeat (400) begin
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(0, 7) == 0);
        fl[i] = ($urandom_range(0, 15) == 0);
      end
      cycle(1'(($urandom_range(0, 3) != 0)), $urandom, 1'(($urandom_range(0, 3) != 0)), st, fl);
    end
    idle(8, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_valid_chain.md
Name: pipe_valid_chain

Overview:
Parametrised pipeline register chain that carries a data word and a valid bit through STAGES stages. It supports per-stage stall and flush, ready/valid handshakes at both ends, optional bubble collapsing, and an occupancy count. It is the generalised replacement for the fixed enable/flush register strings used between the fetch, decode, execute, memory and writeback stages of the rv32 core. The core instantiates one chain per stage-carried field group.

Parameters:
WIDTH, 32, bits of payload per stage
STAGES, 5, number of register stages (>=1)
COLLAPSE, 1, 1 = per-stage advance with bubble squeezing; 0 = lockstep advance of whole chain

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream offers payload
in_data  in  WIDTH  upstream payload
in_ready  out  1  chain accepts in_data this cycle
stall  in  STAGES  stall[i]: stage i holds its contents, neither accepts nor releases
flush  in  STAGES  flush[i]: kill stage i at next edge
out_valid  out  1  last stage presents payload
out_data  out  WIDTH  last-stage payload
out_ready  in  1  downstream takes payload
stage_valid  out  STAGES  valid bit per stage (bit 0 = first stage)
stage_data  out  STAGES*WIDTH  payload per stage, stage i at [i*WIDTH +: WIDTH]
occupancy  out  $clog2(STAGES+1)  count of valid stages

Behaviour:
- Reset (async, rst_n=0): all v[i]=0, all d[i]=0. Outputs follow: out_valid=0, out_data=0, occupancy=0. in_ready is driven by the accept equation (1 unless stall[0], or stall on any stage when COLLAPSE=0). Reset mid-stream discards all contents; nothing is emitted after release.
- Notation: v[i], d[i] are the stage registers. up_v(0)=in_valid, up_d(0)=in_data. up_v(i)=v[i-1] & !flush[i-1] & !stall[i-1] for i>0, and up_d(i)=d[i-1].
- COLLAPSE=1 accept chain, combinational from the tail:
  - acc[STAGES]=out_ready.
  - acc[i] = !stall[i] & (!v[i] | acc[i+1]).
- COLLAPSE=0:
  - adv = !(|stall) & (!v[STAGES-1] | out_ready).
  - acc[i]=adv for all i.
- Next state per stage:
  - v[i] <= flush[i] ? 0 : acc[i] ? up_v(i) : v[i].
  - d[i] <= acc[i] ? up_d(i) : d[i]. Data loads even for bubbles; valid gates its meaning.
- Flush priority: flush over load and over hold. An item moving into a flushed stage in the same cycle is killed. A flushed stage's current item never propagates, even if the next stage accepts that cycle.
- Simultaneous flush of several stages is independent per stage.
- Handshakes:
  - in_ready=acc[0]. Transfer in when in_valid & in_ready.
  - out_valid = v[STAGES-1] & !stall[STAGES-1] & !flush[STAGES-1].
  - out_data=d[STAGES-1]. Transfer out when out_valid & out_ready.
- No combinational path from in_valid/in_data to out_valid/out_data.
- in_ready depends combinationally on out_ready and stall; no path from in_valid to in_ready.
- Latency: an accepted item appears on out_valid exactly STAGES cycles later when unstalled. Throughput is 1 item/cycle.
- Full: all v=1, out_ready=0, COLLAPSE=1 -> in_ready=0. With out_ready=1 and no stalls, in_ready=1 (accept and release in the same cycle).
- Empty stages always accept (COLLAPSE=1) regardless of downstream, unless stalled.
- occupancy = popcount(v), registered-state based, range 0..STAGES.
- STAGES=1 is legal. Behaviour reduces to a single-entry register with the same rules.

Decomposition:
- Shared package pipe_pkg: typedef pipe_mode_t {PIPE_LOCKSTEP, PIPE_COLLAPSE}; function popcount helper; localparam OCC_W rule.
- COLLAPSE stays an int parameter mapped to pipe_mode_t internally.
- One natural sub-module: pipe_stage_reg, a single stage holding v/d with flush/accept inputs. It is generated STAGES times.
- Accept chain and occupancy stay in the top.

Test Plan:
1. STAGES=5, COLLAPSE=1, out_ready=1, push 0x10..0x14 on consecutive cycles -> out_data 0x10..0x14 on cycles 5..9 after first accept, out_valid continuous, occupancy peaks at 5.
2. out_ready=0, offer 7 items -> exactly 5 accepted, in_ready=0 afterwards, occupancy=5; raise out_ready -> 5 items drain in order, in_ready returns 1 on first drain cycle.
3. out_ready=0, push 0xA, idle one cycle, push 0xB -> COLLAPSE=1: 0xA in stage 4, 0xB in stage 3 (no gap); COLLAPSE=0: gap stays and chain stops once 0xA reaches stage 4.
4. Stream with out_ready=1, assert stall[2] for 3 cycles -> stage 2 payload frozen, stages 3-4 drain, stages 0-1 fill then in_ready=0; ordering preserved after release, no duplicate or lost item.
5. Full chain 0x1..0x5, assert flush[1] and flush[3] same cycle while in_valid=1 with 0x6 -> next cycle those stages are invalid, occupancy drops by 2 (plus any killed mover), and 0x2/0x4 never appear on out_data.
6. Mid-stream rst_n=0 for 1 cycle asynchronously between edges -> stage_valid=0 and occupancy=0 immediately; no output after release until new input has propagated 5 cycles.
